switch_input_conditioner: RTL

Synchronises and debounces the raw board slide switches before they reach the memory controller's `sw_i` input. Reads of the memory-mapped switch register therefore return clean, glitch-free levels. The block also produces one-cycle rise and fall pulses per switch for future interrupt or event logic. It sits between the top-level switch pins and the memory controller, one instance per design.

---
 rtl/switch_input_conditioner_pkg.sv | 12 +
 rtl/switch_input_conditioner_debounce_bit.sv | 82 ++++++++
 rtl/switch_input_conditioner.sv | 44 ++++
 3 files changed

// File: rtl/switch_input_conditioner_pkg.sv
// Shared SoC constants and the per-bit debounce state type.
package switch_input_conditioner_pkg;

  localparam int unsigned BOARD_CLK_HZ    = 100_000_000;
  localparam int unsigned DEBOUNCE_CYCLES = BOARD_CLK_HZ / 1000;

  typedef enum logic {
    DB_STABLE = 1'b0,
    DB_COUNT  = 1'b1
  } db_state_t;

endpackage

// File: rtl/switch_input_conditioner_debounce_bit.sv
// One switch bit: two-flop synchroniser, debounce state machine and edge pulses.
module debounce_bit
  import switch_input_conditioner_pkg::*;
#(
  parameter int CNT_MAX = 4,
  parameter int CNT_W   = $clog2(CNT_MAX)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_i,
  output logic sw_o,
  output logic rise_o,
  output logic fall_o,
  output logic accept_d_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CNT_MAX - 1);

  logic             meta_q;
  logic             sync_q;
  logic             sw_q;
  logic             rise_q;
  logic             fall_q;
  logic [CNT_W-1:0] cnt_q;
  db_state_t        state_q;
  logic             accept_d;

  // Asserted on the edge where the new level is taken; the top registers it alongside the pulses.
  always_comb begin
    accept_d = 1'b0;
    if (state_q == DB_COUNT && sync_q != sw_q && cnt_q == CntLast) accept_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      sw_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= DB_STABLE;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        DB_STABLE: begin
          if (sync_q != sw_q) begin
            state_q <= DB_COUNT;
            cnt_q   <= CNT_W'(1);
          end
        end
        DB_COUNT: begin
          if (sync_q == sw_q) begin
            state_q <= DB_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            sw_q    <= sync_q;
            rise_q  <= sync_q;
            fall_q  <= ~sync_q;
            state_q <= DB_STABLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= DB_STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign sw_o       = sw_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign accept_d_o = accept_d;

endmodule

// File: rtl/switch_input_conditioner.sv
// Debounces WIDTH slide switches and flags any accepted change with a one-cycle pulse.
module switch_input_conditioner
  import switch_input_conditioner_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int CNT_MAX = int'(DEBOUNCE_CYCLES),
  parameter int CNT_W   = $clog2(CNT_MAX)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             any_change_o
);

  logic [WIDTH-1:0] accept_d;
  logic             any_change_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .CNT_MAX(CNT_MAX),
      .CNT_W  (CNT_W)
    ) u_bit (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .raw_i     (raw_i[i]),
      .sw_o      (sw_o[i]),
      .rise_o    (rise_o[i]),
      .fall_o    (fall_o[i]),
      .accept_d_o(accept_d[i])
    );
  end

  // Registered from the per-bit accept strobes so it lines up with rise_o/fall_o.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) any_change_q <= 1'b0;
    else          any_change_q <= |accept_d;
  end

  assign any_change_o = any_change_q;

endmodule
